// File: rtl/oled_seq_ctrl.sv
// SSD1306 power-up / power-down sequencer with built-in SPI byte shifter and ms timer.
// Steps are read from a small table; the controller owns the PmodOLED pins until INIT_DONE.
module oled_seq_ctrl #(
    parameter int         CLK_FREQ_HZ   = 100000000,
    parameter int         SCLK_HALF     = 16,
    parameter int         VBAT_DELAY_MS = 100,
    parameter int         RES_DELAY_MS  = 1,
    parameter logic [7:0] CONTRAST      = 8'h0F,
    parameter bit         SEG_REMAP     = 1'b0,
    parameter bit         COM_SCAN      = 1'b0,
    parameter logic [7:0] COM_CFG       = 8'h00
) (
    input  logic CLK,
    input  logic RST,
    input  logic START_INIT,
    input  logic START_OFF,
    output logic BUSY,
    output logic INIT_DONE,
    output logic CS,
    output logic DC,
    output logic SCLK,
    output logic SDO,
    output logic RES,
    output logic VBAT,
    output logic VDD
);

    localparam int MS_TICKS = CLK_FREQ_HZ / 1000;
    localparam int TW       = $clog2(MS_TICKS);
    localparam int WIN      = 18 * SCLK_HALF;
    localparam int CW       = $clog2(WIN);
    localparam int HW       = $clog2(SCLK_HALF) + 1;

    localparam logic [4:0] OFF_BASE = 5'd24;

    localparam logic [1:0] K_PIN  = 2'd0;
    localparam logic [1:0] K_SEND = 2'd1;
    localparam logic [1:0] K_WAIT = 2'd2;
    localparam logic [1:0] K_END  = 2'd3;

    // Pin argument: [1:0] selects VDD/RES/VBAT, [2] is the level to drive.
    localparam logic [7:0] P_VDD_ON   = 8'h00;
    localparam logic [7:0] P_VDD_OFF  = 8'h04;
    localparam logic [7:0] P_RES_LO   = 8'h01;
    localparam logic [7:0] P_RES_HI   = 8'h05;
    localparam logic [7:0] P_VBAT_ON  = 8'h02;
    localparam logic [7:0] P_VBAT_OFF = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SPI_SEND, S_DELAY, S_FINISH
    } state_t;

    state_t        state;
    logic [4:0]    step;
    logic          off_mode;
    logic [TW-1:0] tick;
    logic [11:0]   ms_cnt;
    logic [11:0]   wait_ms;
    logic [CW-1:0] cnt;
    logic [HW-1:0] h_cnt;
    logic [4:0]    half_idx;
    logic [7:0]    shreg;

    logic [1:0]    kind;
    logic [7:0]    arg;

    // Wait argument 0 selects the reset/settle delay, 1 the VBAT delay.
    always_comb begin
        kind = K_END;
        arg  = 8'h00;
        case (step)
            5'd0:  begin kind = K_PIN;  arg = P_VDD_ON;  end
            5'd1:  begin kind = K_WAIT; arg = 8'h00;     end
            5'd2:  begin kind = K_SEND; arg = 8'hAE;     end
            5'd3:  begin kind = K_PIN;  arg = P_RES_LO;  end
            5'd4:  begin kind = K_WAIT; arg = 8'h00;     end
            5'd5:  begin kind = K_PIN;  arg = P_RES_HI;  end
            5'd6:  begin kind = K_WAIT; arg = 8'h00;     end
            5'd7:  begin kind = K_SEND; arg = 8'h8D;     end
            5'd8:  begin kind = K_SEND; arg = 8'h14;     end
            5'd9:  begin kind = K_SEND; arg = 8'hD9;     end
            5'd10: begin kind = K_SEND; arg = 8'hF1;     end
            5'd11: begin kind = K_PIN;  arg = P_VBAT_ON; end
            5'd12: begin kind = K_WAIT; arg = 8'h01;     end
            5'd13: begin kind = K_SEND; arg = 8'h81;     end
            5'd14: begin kind = K_SEND; arg = CONTRAST;  end
            5'd15: begin kind = K_SEND; arg = {7'h50, SEG_REMAP}; end
            5'd16: begin kind = K_SEND; arg = {4'hC, COM_SCAN, 3'b000}; end
            5'd17: begin kind = K_SEND; arg = 8'hDA;     end
            5'd18: begin kind = K_SEND; arg = COM_CFG;   end
            5'd19: begin kind = K_SEND; arg = 8'hAF;     end
            5'd24: begin kind = K_SEND; arg = 8'hAE;     end
            5'd25: begin kind = K_PIN;  arg = P_VBAT_OFF; end
            5'd26: begin kind = K_WAIT; arg = 8'h01;     end
            5'd27: begin kind = K_PIN;  arg = P_VDD_OFF; end
            default: begin kind = K_END; arg = 8'h00;   end
        endcase
    end

    assign DC = 1'b0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            step      <= 5'd0;
            off_mode  <= 1'b0;
            tick      <= '0;
            ms_cnt    <= 12'd0;
            wait_ms   <= 12'd0;
            cnt       <= '0;
            h_cnt     <= '0;
            half_idx  <= 5'd0;
            shreg     <= 8'h00;
            BUSY      <= 1'b0;
            INIT_DONE <= 1'b0;
            CS        <= 1'b1;
            SCLK      <= 1'b1;
            SDO       <= 1'b0;
            RES       <= 1'b1;
            VBAT      <= 1'b1;
            VDD       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START_INIT && !INIT_DONE) begin
                        BUSY     <= 1'b1;
                        step     <= 5'd0;
                        off_mode <= 1'b0;
                        state    <= S_FETCH;
                    end else if (START_OFF && INIT_DONE) begin
                        BUSY     <= 1'b1;
                        step     <= OFF_BASE;
                        off_mode <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    case (kind)
                        K_PIN: begin
                            case (arg[1:0])
                                2'd0:    VDD  <= arg[2];
                                2'd1:    RES  <= arg[2];
                                default: VBAT <= arg[2];
                            endcase
                            step <= step + 5'd1;
                        end
                        K_SEND: begin
                            CS       <= 1'b0;
                            SDO      <= arg[7];
                            shreg    <= arg;
                            cnt      <= '0;
                            h_cnt    <= '0;
                            half_idx <= 5'd0;
                            step     <= step + 5'd1;
                            state    <= S_SPI_SEND;
                        end
                        K_WAIT: begin
                            wait_ms <= arg[0] ? 12'(VBAT_DELAY_MS) : 12'(RES_DELAY_MS);
                            tick    <= '0;
                            ms_cnt  <= 12'd0;
                            step    <= step + 5'd1;
                            state   <= S_DELAY;
                        end
                        default: state <= S_FINISH;
                    endcase
                end
                S_SPI_SEND: begin
                    cnt <= cnt + 1'b1;
                    // Half-period n = half_idx+1: odd n falls SCLK, even n rises, n=17 releases CS.
                    if (h_cnt == HW'(SCLK_HALF - 1)) begin
                        h_cnt    <= '0;
                        half_idx <= half_idx + 5'd1;
                        if (half_idx < 5'd16) begin
                            if (!half_idx[0]) begin
                                SCLK <= 1'b0;
                                if (half_idx != 5'd0) begin
                                    SDO   <= shreg[6];
                                    shreg <= shreg << 1;
                                end
                            end else begin
                                SCLK <= 1'b1;
                            end
                        end else if (half_idx == 5'd16) begin
                            CS  <= 1'b1;
                            SDO <= 1'b0;
                        end
                    end else begin
                        h_cnt <= h_cnt + 1'b1;
                    end
                    // Leaving one cycle early lets the FETCH cycle complete the 18-half window.
                    if (cnt == CW'(WIN - 2))
                        state <= S_FETCH;
                end
                S_DELAY: begin
                    if (ms_cnt == wait_ms - 12'd1 && tick == TW'(MS_TICKS - 2))
                        state <= S_FETCH;
                    if (tick == TW'(MS_TICKS - 1)) begin
                        tick   <= '0;
                        ms_cnt <= ms_cnt + 12'd1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                S_FINISH: begin
                    BUSY      <= 1'b0;
                    INIT_DONE <= !off_mode;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_seq_ctrl.sv
// Directed bench for oled_seq_ctrl: decodes the SPI stream of two parameterisations and
// checks pin ordering, wait lengths, request gating and reset abort.
module tb_oled_seq_ctrl;

    logic clk = 1'b0;
    logic rst, start_init, start_off;
    logic busy, init_done, cs, dc, sclk, sdo, res, vbat, vdd;
    logic a_busy, a_init_done, a_cs, a_dc, a_sclk, a_sdo, a_res, a_vbat, a_vdd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] exp_q[$];
    int cs_fall_q[$];
    int cs_rise_q[$];
    int t_vdd_fall = -1, t_vdd_rise = -1, t_res_fall = -1, t_res_rise = -1;
    int t_vbat_fall = -1, t_vbat_rise = -1, t_init_rise = -1, t_init_fall = -1;
    int t_busy_fall = -1;
    int n_busy_rise = 0;

    logic [7:0] init_main [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                   8'h0F, 8'hA0, 8'hC0, 8'hDA, 8'h00, 8'hAF};
    logic [7:0] init_alt  [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                   8'h7F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};

    oled_seq_ctrl #(
        .CLK_FREQ_HZ(10000), .SCLK_HALF(2), .VBAT_DELAY_MS(100), .RES_DELAY_MS(1),
        .CONTRAST(8'h0F), .SEG_REMAP(1'b0), .COM_SCAN(1'b0), .COM_CFG(8'h00)
    ) u_dut (
        .CLK(clk), .RST(rst), .START_INIT(start_init), .START_OFF(start_off),
        .BUSY(busy), .INIT_DONE(init_done), .CS(cs), .DC(dc), .SCLK(sclk),
        .SDO(sdo), .RES(res), .VBAT(vbat), .VDD(vdd)
    );

    oled_seq_ctrl #(
        .CLK_FREQ_HZ(10000), .SCLK_HALF(2), .VBAT_DELAY_MS(100), .RES_DELAY_MS(1),
        .CONTRAST(8'h7F), .SEG_REMAP(1'b1), .COM_SCAN(1'b1), .COM_CFG(8'h20)
    ) u_alt (
        .CLK(clk), .RST(rst), .START_INIT(start_init), .START_OFF(start_off),
        .BUSY(a_busy), .INIT_DONE(a_init_done), .CS(a_cs), .DC(a_dc), .SCLK(a_sclk),
        .SDO(a_sdo), .RES(a_res), .VBAT(a_vbat), .VDD(a_vdd)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic void chk_range(string tag, int obs, int lo, int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endfunction

    // SPI decoder, byte scoreboard and pin-edge recorder
    logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_asclk = 1'b1;
    logic prev_vdd = 1'b1, prev_res = 1'b1, prev_vbat = 1'b1, prev_init = 1'b0, prev_busy = 1'b0;
    int bits = 0, abits = 0;
    logic [7:0] sh = 8'h00, ash = 8'h00;
    logic [15:0] exp_pair;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            bits = 0; abits = 0;
            prev_cs = 1'b1; prev_sclk = 1'b1; prev_asclk = 1'b1;
            prev_vdd = 1'b1; prev_res = 1'b1; prev_vbat = 1'b1;
            prev_init = 1'b0; prev_busy = 1'b0;
        end else begin
            if (!cs && !prev_sclk && sclk) begin sh = {sh[6:0], sdo}; bits++; end
            if (!a_cs && !prev_asclk && a_sclk) begin ash = {ash[6:0], a_sdo}; abits++; end
            if (prev_cs && !cs) cs_fall_q.push_back(cyc);
            if (!prev_cs && cs) begin
                cs_rise_q.push_back(cyc);
                chk("sclk_rises_per_byte", bits, 8);
                chk("alt_sclk_rises_per_byte", abits, 8);
                if (exp_q.size() > 0) begin
                    exp_pair = exp_q.pop_front();
                    chk("spi_byte_alt_main", {ash, sh}, exp_pair);
                end else begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_byte observed %h expected none", {ash, sh});
                end
                bits = 0; abits = 0;
            end
            if (cs) chk("idle_sclk_sdo", {sclk, sdo, a_sclk, a_sdo}, 4'b1010);
            if (prev_vdd && !vdd) t_vdd_fall = cyc;
            if (!prev_vdd && vdd) t_vdd_rise = cyc;
            if (prev_res && !res) t_res_fall = cyc;
            if (!prev_res && res) t_res_rise = cyc;
            if (prev_vbat && !vbat) t_vbat_fall = cyc;
            if (!prev_vbat && vbat) t_vbat_rise = cyc;
            if (!prev_init && init_done) t_init_rise = cyc;
            if (prev_init && !init_done) t_init_fall = cyc;
            if (!prev_busy && busy) n_busy_rise++;
            if (prev_busy && !busy) t_busy_fall = cyc;
            prev_cs = cs; prev_sclk = sclk; prev_asclk = a_sclk;
            prev_vdd = vdd; prev_res = res; prev_vbat = vbat;
            prev_init = init_done; prev_busy = busy;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse(input logic i, input logic o);
        start_init = i;
        start_off  = o;
        tick(1);
        start_init = 1'b0;
        start_off  = 1'b0;
    endtask

    task automatic wait_init(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (init_done !== lvl && n < budget) begin tick(1); n++; end
        chk(tag, init_done, lvl);
    endtask

    task automatic wait_bytes(input int k, input int budget, input string tag);
        int n = 0;
        while (cs_fall_q.size() < k && n < budget) begin tick(1); n++; end
        chk(tag, cs_fall_q.size() >= k, 1);
    endtask

    task automatic clear_rec();
        cs_fall_q.delete();
        cs_rise_q.delete();
        t_vdd_fall = -1; t_vdd_rise = -1; t_res_fall = -1; t_res_rise = -1;
        t_vbat_fall = -1; t_vbat_rise = -1; t_init_rise = -1; t_init_fall = -1;
        t_busy_fall = -1;
    endtask

    task automatic push_init();
        for (int i = 0; i < 12; i++) exp_q.push_back({init_alt[i], init_main[i]});
    endtask

    initial begin
        rst = 1'b1; start_init = 1'b0; start_off = 1'b0;
        tick(3);
        chk("outputs_in_reset", {busy, init_done, cs, sclk, sdo, dc, res, vbat, vdd}, 9'b001100111);
        rst = 1'b0;
        tick(1);
        chk("outputs_after_reset", {busy, init_done, cs, sclk, sdo, dc, res, vbat, vdd}, 9'b001100111);
        tick(10);
        chk("outputs_idle", {busy, init_done, cs, sclk, sdo, dc, res, vbat, vdd}, 9'b001100111);
        chk("idle_no_cs", cs_fall_q.size(), 0);
        chk("idle_no_busy", n_busy_rise, 0);

        // power-down request before init is ignored
        pulse(1'b0, 1'b1);
        tick(50);
        chk("off_gated_busy", n_busy_rise, 0);
        chk("off_gated_cs", cs_fall_q.size(), 0);

        // power-up, with a stray START_INIT while busy
        clear_rec();
        push_init();
        pulse(1'b1, 1'b0);
        chk("busy_after_start", busy, 1);
        wait_bytes(3, 500, "reach_third_byte");
        pulse(1'b1, 1'b0);
        wait_init(1'b1, 5000, "init_done_rise");
        chk("init_byte_count", cs_fall_q.size(), 12);
        chk("init_single_busy", n_busy_rise, 1);
        chk_range("vdd_to_first_cs", cs_fall_q[0] - t_vdd_fall, 8, 12);
        chk("res_low_after_ae", t_res_fall > cs_rise_q[0], 1);
        chk("res_high_before_8d", t_res_rise < cs_fall_q[1], 1);
        chk_range("res_low_width", t_res_rise - t_res_fall, 8, 12);
        chk("vbat_on_after_f1", t_vbat_fall > cs_rise_q[4], 1);
        chk_range("vbat_to_81", cs_fall_q[5] - t_vbat_fall, 1000, 1002);
        chk("byte_window", cs_fall_q[2] - cs_fall_q[1], 36);
        chk("done_with_busy_fall", t_init_rise, t_busy_fall);
        chk("up_pins", {busy, res, vbat, vdd}, 4'b0100);
        chk("drained_init", exp_q.size(), 0);

        // START_INIT with INIT_DONE=1 is ignored
        tick(5);
        pulse(1'b1, 1'b0);
        tick(50);
        chk("init_gated_busy", n_busy_rise, 1);
        chk("init_gated_cs", cs_fall_q.size(), 12);
        chk("still_done", init_done, 1);

        // both requests together: only power-down acts
        clear_rec();
        exp_q.push_back({8'hAE, 8'hAE});
        pulse(1'b1, 1'b1);
        chk("busy_after_off", busy, 1);
        wait_init(1'b0, 3000, "init_done_fall");
        chk("off_byte_count", cs_fall_q.size(), 1);
        chk("vbat_off_after_ae", t_vbat_rise > cs_rise_q[0], 1);
        chk_range("vbat_to_vdd_off", t_vdd_rise - t_vbat_rise, 1000, 1002);
        chk("off_flags_same_cycle", t_init_fall, t_busy_fall);
        chk("supplies_off", {vbat, vdd, busy}, 3'b110);
        chk("drained_off", exp_q.size(), 0);

        // START_OFF with INIT_DONE=0 is ignored
        tick(5);
        pulse(1'b0, 1'b1);
        tick(50);
        chk("off_gated_busy2", n_busy_rise, 2);
        chk("off_gated_cs2", cs_fall_q.size(), 1);

        // reset in the middle of the third byte
        clear_rec();
        push_init();
        pulse(1'b1, 1'b0);
        wait_bytes(3, 500, "reach_byte_for_reset");
        tick(10);
        rst = 1'b1;
        tick(1);
        chk("reset_abort", {cs, sclk, vbat, vdd, busy}, 5'b11110);
        exp_q.delete();
        rst = 1'b0;
        tick(5);
        chk("reset_clears_done", {init_done, vdd}, 2'b01);

        // full replay after the abort
        clear_rec();
        push_init();
        pulse(1'b1, 1'b0);
        wait_init(1'b1, 5000, "replay_done");
        chk("replay_byte_count", cs_fall_q.size(), 12);
        chk_range("replay_vdd_to_cs", cs_fall_q[0] - t_vdd_fall, 8, 12);
        chk("drained_replay", exp_q.size(), 0);
        chk("final_main", {busy, init_done, dc, res, vbat, vdd}, 6'b010100);
        chk("final_alt", {a_busy, a_init_done, a_dc, a_res, a_vbat, a_vdd, a_cs}, 7'b0101001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
